// File: rtl/bmp_pkg.sv
// Shared constants, FSM state type and BMP header byte lookup for bmp_stream_writer.
// Header bytes are generated from WIDTH/HEIGHT so any image size gets a valid file.
package bmp_pkg;

  localparam int BMP_HEADER_SIZE = 54;
  localparam int BYTES_PER_PIXEL = 3;
  localparam int DIB_SIZE        = 40;
  localparam int BPP             = 24;
  localparam int PPM             = 2835;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PIXEL,
    PAD,
    DONE
  } state_t;

  function automatic int pad_bytes(input int w);
    return (4 - (BYTES_PER_PIXEL * w) % 4) % 4;
  endfunction

  // Bytes 2..53 are thirteen little-endian 32-bit words; planes/bpp share one.
  function automatic logic [7:0] header_byte(
    input logic [5:0] n,
    input int         w,
    input int         h
  );
    int          rowb;
    logic [31:0] isz;
    logic [31:0] fsz;
    logic [31:0] word;
    logic [5:0]  off;
    logic [7:0]  b;
    rowb = BYTES_PER_PIXEL * w + pad_bytes(w);
    isz  = 32'(rowb * h);
    fsz  = isz + 32'(BMP_HEADER_SIZE);
    off  = n - 6'd2;
    case (off[5:2])
      4'd0:    word = fsz;
      4'd2:    word = 32'(BMP_HEADER_SIZE);
      4'd3:    word = 32'(DIB_SIZE);
      4'd4:    word = 32'(w);
      4'd5:    word = 32'(h);
      4'd6:    word = {16'(BPP), 16'd1};
      4'd8:    word = isz;
      4'd9:    word = 32'(PPM);
      4'd10:   word = 32'(PPM);
      default: word = 32'd0;
    endcase
    if (n == 6'd0)
      b = 8'h42;
    else if (n == 6'd1)
      b = 8'h4D;
    else
      b = 8'(word >> {off[1:0], 3'b000});
    return b;
  endfunction

endpackage

// File: rtl/bmp_header_rom.sv
// Index-to-byte lookup for the 54-byte BMP file header.
// Pure combinational; contents fixed by the image geometry parameters.
module bmp_header_rom
  import bmp_pkg::*;
#(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540
) (
  input  logic [5:0] index,
  output logic [7:0] data
);

  always_comb begin
    data = header_byte(index, WIDTH, HEIGHT);
  end

endmodule

// File: rtl/bmp_stream_writer.sv
// Grayscale pixel FIFO to 24-bit BMP byte stream (header, replicated B/G/R, row pad).
// Define BMP_HEADER_EN to emit the 54-byte header; otherwise raw pixels plus pad.
module bmp_stream_writer
  import bmp_pkg::*;
#(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       in_empty,
  output logic       in_rd_en,
  input  logic [7:0] in_dout,
  input  logic       out_full,
  output logic       out_wr_en,
  output logic [7:0] out_din,
  output logic       busy,
  output logic       done
);

  localparam int PADB = pad_bytes(WIDTH);
  localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [1:0]    PAD_LAST = 2'(PADB - 1);
  localparam logic [5:0]    HDR_LAST = 6'(BMP_HEADER_SIZE - 1);

`ifdef BMP_HEADER_EN
  localparam state_t FIRST = HEADER;
`else
  localparam state_t FIRST = PIXEL;
`endif

  state_t        state;
  state_t        state_nx;
  logic [5:0]    byte_idx;
  logic [1:0]    sub;
  logic [1:0]    pad_cnt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [7:0]    hdr_byte;

  logic avail;
  logic wr;
  logic go;
  logic hdr_last;
  logic pix_last;
  logic col_last;
  logic row_last;
  logic pad_last;
  logic row_end;

  bmp_header_rom #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_rom (
    .index (byte_idx),
    .data  (hdr_byte)
  );

  assign go       = start && (state == IDLE || state == DONE);
  assign hdr_last = (byte_idx == HDR_LAST);
  assign pix_last = (sub == 2'd2);
  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  assign pad_last = (pad_cnt == PAD_LAST);

  // A row ends on its last pixel byte when unpadded, else on its last pad byte.
  assign row_end = wr && (
    (state == PIXEL && pix_last && col_last && PADB == 0) ||
    (state == PAD && pad_last));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      byte_idx <= '0;
      sub      <= '0;
      pad_cnt  <= '0;
      col      <= '0;
      row      <= '0;
    end else begin
      state <= state_nx;
      if (go) begin
        byte_idx <= '0;
        sub      <= '0;
        pad_cnt  <= '0;
        col      <= '0;
        row      <= '0;
      end else if (wr) begin
        if (state == HEADER)
          byte_idx <= hdr_last ? 6'd0 : byte_idx + 6'd1;
        if (state == PIXEL) begin
          sub <= pix_last ? 2'd0 : sub + 2'd1;
          if (pix_last)
            col <= col_last ? '0 : col + CW'(1);
        end
        if (state == PAD)
          pad_cnt <= pad_last ? 2'd0 : pad_cnt + 2'd1;
        if (row_end)
          row <= row_last ? '0 : row + RW'(1);
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (go)
          state_nx = FIRST;
      end
      HEADER: begin
        if (wr && hdr_last)
          state_nx = PIXEL;
      end
      PIXEL: begin
        if (wr && pix_last && col_last) begin
          if (PADB > 0)
            state_nx = PAD;
          else if (row_last)
            state_nx = DONE;
        end
      end
      PAD: begin
        if (wr && pad_last)
          state_nx = row_last ? DONE : PIXEL;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    avail   = 1'b0;
    out_din = 8'h00;
    unique case (1'b1)
      state == HEADER: begin
        avail   = 1'b1;
        out_din = hdr_byte;
      end
      state == PIXEL: begin
        avail   = !in_empty;
        out_din = in_dout;
      end
      state == PAD: avail = 1'b1;
      default: ;
    endcase
    wr        = avail && !out_full;
    out_wr_en = wr;
    in_rd_en  = wr && state == PIXEL && pix_last;
    busy      = state == HEADER || state == PIXEL || state == PAD;
    done      = state == DONE;
  end

endmodule

// File: tb/tb_bmp_stream_writer.sv
// Scoreboard bench for bmp_stream_writer at 5x2 (one pad byte per row).
// Works with or without BMP_HEADER_EN defined.
module tb_bmp_stream_writer;
  import bmp_pkg::*;

  localparam int W = 5;
  localparam int H = 2;
`ifdef BMP_HEADER_EN
  localparam int HDR_N = 54;
`else
  localparam int HDR_N = 0;
`endif
  localparam int FRAME_N = HDR_N + 32;

  typedef struct packed {
    logic [7:0] b;
    logic       rd;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       in_empty = 1'b1;
  logic [7:0] in_dout = 8'h00;
  logic       out_full = 1'b0;
  logic       in_rd_en;
  logic       out_wr_en;
  logic [7:0] out_din;
  logic       busy;
  logic       done;

  exp_t       exp_q[$];
  logic [7:0] src_q[$];
  logic [7:0] hdr[54];
  logic [7:0] pa[10];
  logic [7:0] pb[10];
  logic [7:0] pc[10];
  int         checks = 0;
  int         errors = 0;
  int         wr_count = 0;
  int         full_cycles = 0;
  bit         pop_pending = 0;
  bit         rand_empty = 0;

  bmp_stream_writer #(
    .WIDTH  (W),
    .HEIGHT (H)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .in_dout   (in_dout),
    .out_full  (out_full),
    .out_wr_en (out_wr_en),
    .out_din   (out_din),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  // Upstream show-ahead FIFO and downstream full model.
  always @(posedge clock) begin
    #1;
    if (pop_pending) begin
      if (src_q.size() > 0)
        void'(src_q.pop_front());
      pop_pending = 0;
    end
    if (full_cycles > 0) begin
      out_full = 1'b1;
      full_cycles--;
    end else begin
      out_full = 1'b0;
    end
    in_empty = (src_q.size() == 0) ||
               (rand_empty && $urandom_range(0, 1) == 1);
    in_dout = (src_q.size() > 0) ? src_q[0] : 8'h00;
  end

  // Monitor: every written byte must match the next scoreboard entry.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      if (out_full) begin
        checks++;
        if (out_wr_en !== 1'b0) begin
          errors++;
          $display("FAIL wr_while_full got wr=%b want 0", out_wr_en);
        end
      end
      if (out_wr_en === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_byte got %h want none", out_din);
        end else begin
          e = exp_q.pop_front();
          if (out_din !== e.b || in_rd_en !== e.rd) begin
            errors++;
            $display("FAIL byte%0d got %h rd=%b want %h rd=%b",
                     wr_count, out_din, in_rd_en, e.b, e.rd);
          end
        end
        wr_count++;
        if (in_rd_en === 1'b1)
          pop_pending = 1;
      end else if (in_rd_en !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL pop_without_write got rd=%b want 0", in_rd_en);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic push_frame(input logic [7:0] px[10]);
    for (int i = 0; i < HDR_N; i++)
      exp_q.push_back({hdr[i], 1'b0});
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        exp_q.push_back({px[r*W+c], 1'b0});
        exp_q.push_back({px[r*W+c], 1'b0});
        exp_q.push_back({px[r*W+c], 1'b1});
        src_q.push_back(px[r*W+c]);
      end
      exp_q.push_back({8'h00, 1'b0});
    end
  endtask

  task automatic start_frame();
    wr_count = 0;
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input string name);
    int k = 0;
    while (wr_count < n && k < 4000) begin
      @(posedge clock);
      #2;
      k++;
    end
    check(name, 32'(wr_count >= n), 1);
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (done !== 1'b1 && k < 4000) begin
      @(negedge clock);
      k++;
    end
    check({name, "_done"}, done, 1);
    check({name, "_busy"}, busy, 0);
    check({name, "_left"}, exp_q.size(), 0);
    check({name, "_count"}, wr_count, FRAME_N);
  endtask

  logic [5:0] hi[14];
  logic [7:0] hv[14];

  initial begin
    hdr = '{8'h42, 8'h4D, 8'h56, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00,
            8'h36, 8'h00, 8'h00, 8'h00,
            8'h28, 8'h00, 8'h00, 8'h00,
            8'h05, 8'h00, 8'h00, 8'h00,
            8'h02, 8'h00, 8'h00, 8'h00,
            8'h01, 8'h00, 8'h18, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00,
            8'h20, 8'h00, 8'h00, 8'h00,
            8'h13, 8'h0B, 8'h00, 8'h00,
            8'h13, 8'h0B, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00};
    pa = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
           8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    pb = '{8'h5A, 8'h11, 8'h22, 8'h33, 8'h44,
           8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    pc = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4,
           8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9};
    hi = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd18,
           6'd19, 6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25};
    hv = '{8'h42, 8'h4D, 8'h76, 8'hCC, 8'h11, 8'h00, 8'hD0,
           8'h02, 8'h00, 8'h00, 8'h1C, 8'h02, 8'h00, 8'h00};

    // Reset with upstream data present: nothing may be popped or written.
    src_q.push_back(8'h77);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr", out_wr_en, 0);
    check("rst_rd", in_rd_en, 0);
    check("rst_din", out_din, 0);
    src_q.delete();
    @(posedge clock);
    #2 reset = 1'b1;

    for (int i = 0; i < 14; i++)
      check($sformatf("hdr720x540_%0d", hi[i]),
            header_byte(hi[i], 720, 540), hv[i]);

    // Frame A: unstalled ramp.
    push_frame(pa);
    start_frame();
    check("latency_wr", out_wr_en, 1);
    check("busy_run", busy, 1);
    wait_done("frameA");

    // Frame B: restart from DONE with random empties and a full stall.
    push_frame(pb);
    rand_empty = 1;
    start_frame();
    check("done_cleared", done, 0);
    wait_bytes(HDR_N + 7, "reach_stall");
    full_cycles = 10;
    wait_done("frameB");
    rand_empty = 0;

    // Frame C: reset mid-pixel, then a clean frame D.
    push_frame(pc);
    start_frame();
    wait_bytes(HDR_N + 4, "reach_reset");
    reset = 1'b0;
    exp_q.delete();
    src_q.delete();
    @(negedge clock);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_wr", out_wr_en, 0);
    check("midrst_rd", in_rd_en, 0);
    @(posedge clock);
    #2 reset = 1'b1;
    push_frame(pa);
    start_frame();
    wait_done("frameD");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bmp_stream_writer.md
BMP_STREAM_WRITER -- requirements
Module: bmp_stream_writer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 720, meaning image width in pixels.
REQ-002 The block SHALL have parameter HEIGHT, default 540, meaning image height in pixels.
REQ-003 The block SHALL have port clock, input, 1 bit: clock, rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: one-cycle pulse that begins one frame.
REQ-006 The block SHALL have port in_empty, input, 1 bit: upstream grayscale FIFO empty.
REQ-007 The block SHALL have port in_rd_en, output, 1 bit: pops the upstream FIFO.
REQ-008 The block SHALL have port in_dout, input, 8 bits: upstream gray pixel, show-ahead, valid while in_empty=0.
REQ-009 The block SHALL have port out_full, input, 1 bit: downstream byte FIFO full.
REQ-010 The block SHALL have port out_wr_en, output, 1 bit: pushes out_din.
REQ-011 The block SHALL have port out_din, output, 8 bits: BMP file byte.
REQ-012 The block SHALL have port busy, output, 1 bit: frame in progress.
REQ-013 The block SHALL have port done, output, 1 bit: sticky frame-complete flag.

Function
REQ-014 The block SHALL use FSM states IDLE, HEADER, PIXEL, PAD, DONE.
REQ-015 Transitions SHALL be: IDLE/DONE --start--> HEADER; HEADER --54th byte written--> PIXEL; PIXEL --last byte of row--> PAD if PADB>0, else next row or DONE; PAD --PADB bytes written--> PIXEL or DONE.
REQ-016 Row pad PADB SHALL equal (4 - (3*WIDTH) mod 4) mod 4, and pad bytes SHALL be 0x00.
REQ-017 The header SHALL be 54 bytes, little-endian: "BM", file size 54+(3*WIDTH+PADB)*HEIGHT, 4 reserved zero bytes, offset 54, DIB size 40, WIDTH, HEIGHT as positive bottom-up, planes 1, bpp 24, compression 0, image size (3*WIDTH+PADB)*HEIGHT, x/y ppm 2835, colors 0, important 0.
REQ-018 Each gray pixel SHALL be emitted as three identical bytes (B,G,R = in_dout) on three write cycles.
REQ-019 out_wr_en SHALL be combinational and high only when out_full=0 and the current byte is available. In PIXEL this also requires in_empty=0.
REQ-020 in_rd_en SHALL be high only in the cycle where the third copy of a pixel is written.
REQ-021 With out_full=1, or in_empty=1 in PIXEL, the block SHALL stall with no write, no pop, and no state or counter change.
REQ-022 The byte index (0..53), sub-byte counter (0..2), column counter and row counter SHALL wrap to 0 at their limits.
REQ-023 start SHALL be ignored outside IDLE/DONE. start in DONE SHALL clear done and begin a new frame.
REQ-024 busy SHALL be high in HEADER, PIXEL and PAD.
REQ-025 done SHALL assert on the cycle after the final byte is written.
REQ-026 Throughput SHALL be one byte per cycle when unstalled.
REQ-027 Latency from start to the first out_wr_en SHALL be one cycle.

Reset
REQ-028 When reset is low, the block SHALL enter IDLE asynchronously and clear all counters.
REQ-029 During reset, busy, done, in_rd_en and out_wr_en SHALL be 0 and out_din SHALL be 0x00.
REQ-030 Reset mid-frame SHALL abandon the frame. No partial pixel SHALL be popped afterwards.

Configuration
REQ-031 With macro BMP_HEADER_EN defined, the block SHALL emit the 54-byte header per REQ-017.
REQ-032 Without BMP_HEADER_EN, the HEADER state SHALL be bypassed, start SHALL go directly to PIXEL, and the stream SHALL be raw pixels plus pad only.

Structure
REQ-033 Package bmp_pkg SHALL hold: BMP_HEADER_SIZE=54, BYTES_PER_PIXEL=3, DIB_SIZE=40, BPP=24, PPM=2835, the FSM state enum typedef, and a function returning header byte n for a given WIDTH and HEIGHT.
REQ-034 The block SHALL contain one sub-module, bmp_header_rom: an index-to-byte lookup using the package function.

Verification
REQ-035 Header bytes: WIDTH=720, HEIGHT=540, BMP_HEADER_EN defined, start -> bytes 0..5 = 42 4D 76 CC 11 00, bytes 18..21 = D0 02 00 00, bytes 22..25 = 1C 02 00 00.
REQ-036 Pixel replication: upstream pixel 0x5A -> three consecutive writes 5A 5A 5A with in_rd_en high only on the third.
REQ-037 Padding: WIDTH=5, HEIGHT=2, gray ramp 1..10 -> each row is 15 pixel bytes + 1 byte 0x00; total 54+32=86 bytes; done=1.
REQ-038 Backpressure: out_full held high 10 cycles mid-pixel, and in_empty toggled randomly -> byte stream identical to the unstalled run; no write while full.
REQ-039 Reset: reset asserted at byte 100, then start -> stream restarts at byte 0 (0x42); busy=0 and done=0 while reset is asserted.
REQ-040 Macro absent: WIDTH=720, HEIGHT=540 -> first byte = first pixel value; 1,166,400 total bytes.
